arcade_sequencer: RTL and testbench

ARCADE_SEQUENCER -- requirements
Module: arcade_sequencer

---
 rtl/arcade_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/arcade_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_arcade_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_pkg.sv
// arcade_pkg: shared definitions for the arcade sequencer slice.
//   - state_t        : sequencer FSM states
//   - DEF_NUM_GAMES  : default number of attached games
//   - DEF_TICK_DIV   : default clk cycles per game tick
//   - menu geometry  : bar placement on the 640x480 menu screen
//   - menu colours   : 12-bit {r,g,b} colours used by the menu renderer
package arcade_pkg;

    typedef enum logic [1:0] {
        ST_MENU,
        ST_LAUNCH,
        ST_RUN,
        ST_RESULT
    } state_t;

    localparam int DEF_NUM_GAMES = 4;
    localparam int DEF_TICK_DIV  = 500000;

    // Number of clk cycles a game is held in reset before it starts running.
    localparam int LAUNCH_CYCLES = 2;

    // Menu bars: bar i covers BAR_X_MIN <= x < BAR_X_MAX and
    // BAR_Y_BASE + BAR_PITCH*i <= y < BAR_Y_BASE + BAR_PITCH*i + BAR_HEIGHT.
    localparam int BAR_X_MIN  = 200;
    localparam int BAR_X_MAX  = 440;
    localparam int BAR_Y_BASE = 100;
    localparam int BAR_PITCH  = 80;
    localparam int BAR_HEIGHT = 60;

    localparam logic [11:0] COLOR_SEL   = 12'hFFF;
    localparam logic [11:0] COLOR_UNSEL = 12'h444;
    localparam logic [11:0] COLOR_BG    = 12'h000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw active-low pushbutton.
//   The button passes a 2-flop synchroniser, is sampled once per game tick,
//   and a press is reported when the sampled level goes 1 -> 0 between two
//   consecutive ticks.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset (everything reads "released")
//   tick   in  one-cycle game tick strobe
//   btn_n  in  raw active-low button
//   press  out one-cycle press pulse, registered on the sampling tick
module btn_debounce
    import arcade_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic sample;

    // The sample only moves on ticks, so bounce shorter than a tick is
    // invisible; the press pulse is cleared on every other cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sample <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (tick) begin
                sample <= sync_2;
                press  <= sample & ~sync_2;
            end
        end
    end

endmodule

// File: rtl/arcade_sequencer.sv
// arcade_sequencer: menu + launcher for up to four small VGA games.
//   MENU shows one bar per game and lets the player pick with up/down,
//   sel launches the chosen game (2-cycle reset pulse), RUN hands the screen
//   to that game until its done flag, RESULT freezes it on screen for
//   RESULT_TICKS ticks, then control returns to MENU.
// Optional feature: define ARCADE_IDLE_TIMEOUT_EN to abort a game back to
//   MENU after IDLE_TICKS ticks in RUN without any button press.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   x [9:0], y [8:0]              current VGA pixel position
//   btn_up_n/btn_down_n/btn_sel_n raw active-low buttons
//   game_done  [NUM_GAMES]        per-game done level
//   game_rgb   [12*NUM_GAMES]     per-game pixel, game i at [12i+11:12i]
//   game_rst_n [NUM_GAMES]        per-game active-low reset
//   game_start [NUM_GAMES]        one-hot run enable
//   active_game [1:0]             current selection
//   vga_r/vga_g/vga_b [3:0]       muxed pixel colour
module arcade_sequencer
    import arcade_pkg::*;
#(
    parameter int NUM_GAMES    = DEF_NUM_GAMES,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int RESULT_TICKS = 200,
    parameter int IDLE_TICKS   = 6000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              x,
    input  logic [8:0]              y,
    input  logic                    btn_up_n,
    input  logic                    btn_down_n,
    input  logic                    btn_sel_n,
    input  logic [NUM_GAMES-1:0]    game_done,
    input  logic [12*NUM_GAMES-1:0] game_rgb,
    output logic [NUM_GAMES-1:0]    game_rst_n,
    output logic [NUM_GAMES-1:0]    game_start,
    output logic [1:0]              active_game,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RESULT_TICKS + 1);
    localparam logic [1:0] LAST_SEL = 2'(NUM_GAMES - 1);

    if (NUM_GAMES < 2 || NUM_GAMES > 4 || TICK_DIV < 2 ||
        RESULT_TICKS < 1 || IDLE_TICKS < 1) begin : g_bad_params
        $error("arcade_sequencer: parameter out of range");
    end

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          press_up;
    logic          press_down;
    logic          press_sel;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic          launch_q, launch_d;
    logic [RW-1:0] res_q, res_d;

    logic [11:0]   game_pix;
    logic [11:0]   menu_pix;
    logic [11:0]   vga_pix;

    // Free-running tick divider shared by the buttons and the FSM timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    btn_debounce u_btn_up (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .btn_n(btn_up_n),
        .press(press_up)
    );

    btn_debounce u_btn_down (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .btn_n(btn_down_n),
        .press(press_down)
    );

    btn_debounce u_btn_sel (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .btn_n(btn_sel_n),
        .press(press_sel)
    );

`ifdef ARCADE_IDLE_TIMEOUT_EN
    localparam int IW = $clog2(IDLE_TICKS + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          any_press;
    assign any_press = press_up | press_down | press_sel;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_MENU;
            sel_q    <= 2'd0;
            launch_q <= 1'b0;
            res_q    <= '0;
`ifdef ARCADE_IDLE_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            launch_q <= launch_d;
            res_q    <= res_d;
`ifdef ARCADE_IDLE_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    // Next-state logic. sel only moves in MENU; a sel press beats a
    // simultaneous up/down, and up+down together cancel out.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        launch_d = launch_q;
        res_d    = res_q;
`ifdef ARCADE_IDLE_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        case (state_q)
            ST_MENU: begin
                if (press_sel) begin
                    state_d  = ST_LAUNCH;
                    launch_d = 1'b0;
                end else if (press_up && !press_down) begin
                    sel_d = (sel_q == 2'd0) ? LAST_SEL : sel_q - 2'd1;
                end else if (press_down && !press_up) begin
                    sel_d = (sel_q == LAST_SEL) ? 2'd0 : sel_q + 2'd1;
                end
            end
            ST_LAUNCH: begin
                // launch_q marks the second LAUNCH cycle.
                if (launch_q) begin
                    state_d = ST_RUN;
`ifdef ARCADE_IDLE_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end else begin
                    launch_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (game_done[sel_q]) begin
                    state_d = ST_RESULT;
                    res_d   = '0;
                end
`ifdef ARCADE_IDLE_TIMEOUT_EN
                else if (any_press) begin
                    idle_d = '0;
                end else if (tick) begin
                    if (idle_q == IW'(IDLE_TICKS - 1)) begin
                        state_d = ST_MENU;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
            ST_RESULT: begin
                if (tick) begin
                    if (res_q == RW'(RESULT_TICKS - 1)) begin
                        state_d = ST_MENU;
                    end else begin
                        res_d = res_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    assign game_pix = game_rgb[12*sel_q +: 12];

    // Menu renderer: purely combinational from x, y and the selection.
    always_comb begin
        menu_pix = COLOR_BG;
        if (x >= 10'(BAR_X_MIN) && x < 10'(BAR_X_MAX)) begin
            for (int i = 0; i < NUM_GAMES; i++) begin
                if (y >= 9'(BAR_Y_BASE + BAR_PITCH * i) &&
                    y <  9'(BAR_Y_BASE + BAR_PITCH * i + BAR_HEIGHT)) begin
                    menu_pix = (sel_q == 2'(i)) ? COLOR_SEL : COLOR_UNSEL;
                end
            end
        end
    end

    // Game control and screen source per state. LAUNCH blanks the screen
    // while the chosen game is held in reset.
    always_comb begin
        game_rst_n = '0;
        game_start = '0;
        vga_pix    = menu_pix;
        case (state_q)
            ST_LAUNCH: begin
                vga_pix = COLOR_BG;
            end
            ST_RUN: begin
                game_rst_n[sel_q] = 1'b1;
                game_start[sel_q] = 1'b1;
                vga_pix           = game_pix;
            end
            ST_RESULT: begin
                game_rst_n[sel_q] = 1'b1;
                vga_pix           = game_pix;
            end
            default: begin
                vga_pix = menu_pix;
            end
        endcase
    end

    assign active_game = sel_q;
    assign vga_r       = vga_pix[11:8];
    assign vga_g       = vga_pix[7:4];
    assign vga_b       = vga_pix[3:0];

endmodule

// File: tb/tb_arcade_sequencer.sv
// tb_arcade_sequencer: randomized self-checking bench for arcade_sequencer
// (NUM_GAMES=4, TICK_DIV=4, RESULT_TICKS=3, IDLE_TICKS=10). Honors
// ARCADE_IDLE_TIMEOUT_EN the same way the design does.
module tb_arcade_sequencer;

    localparam int NG = 4;
    localparam int TD = 4;
    localparam int RT = 3;
    localparam int IT = 10;

    logic            clk;
    logic            rst;
    logic [9:0]      x;
    logic [8:0]      y;
    logic            btn_up_n;
    logic            btn_down_n;
    logic            btn_sel_n;
    logic [NG-1:0]   game_done;
    logic [12*NG-1:0] game_rgb;
    logic [NG-1:0]   game_rst_n;
    logic [NG-1:0]   game_start;
    logic [1:0]      active_game;
    logic [3:0]      vga_r;
    logic [3:0]      vga_g;
    logic [3:0]      vga_b;
    logic [11:0]     vga;

    int vectors;
    int miscompares;
    int cyc;
    int model_sel;

    assign vga = {vga_r, vga_g, vga_b};

    arcade_sequencer #(
        .NUM_GAMES   (NG),
        .TICK_DIV    (TD),
        .RESULT_TICKS(RT),
        .IDLE_TICKS  (IT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .btn_sel_n  (btn_sel_n),
        .game_done  (game_done),
        .game_rgb   (game_rgb),
        .game_rst_n (game_rst_n),
        .game_start (game_start),
        .active_game(active_game),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; ticks fall in cycles after edges
    // with cyc % TD == TD-1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [47:0] got,
                               input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] menuPixel(input int px, input int py, input int s);
        int bar;
        if (px < 200 || px >= 440 || py < 100) return 12'h000;
        bar = (py - 100) / 80;
        if (bar >= NG || ((py - 100) % 80) >= 60) return 12'h000;
        return (bar == s) ? 12'hFFF : 12'h444;
    endfunction

    function automatic logic [11:0] slice(input int g);
        return game_rgb[12*g +: 12];
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic alignPhase(input int p);
        for (int i = 0; i < TD; i++) begin
            if (cyc % TD == p) break;
            stepCycle();
        end
    endtask

    // Holds the chosen buttons for two ticks and releases them for two.
    task automatic applyStimulus(input bit up, input bit dn);
        alignPhase(0);
        btn_up_n   = ~up;
        btn_down_n = ~dn;
        repeat (2 * TD) stepCycle();
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        repeat (2 * TD) stepCycle();
        if (up && !dn) model_sel = (model_sel + NG - 1) % NG;
        if (dn && !up) model_sel = (model_sel + 1) % NG;
        checkOutput("menu_sel", active_game, model_sel);
    endtask

    task automatic navigateTo(input int g);
        for (int i = 0; i < NG && model_sel != g; i++) applyStimulus(1'b0, 1'b1);
    endtask

    task automatic pointAtBar(input int g);
        x = 10'd300;
        y = 9'(100 + 80 * g + 10);
        #1;
    endtask

    // Launches the current selection; optionally with up pressed the same tick.
    task automatic launchGame(input int g, input bit with_up);
        int lc;
        bit running;
        for (int i = 0; i < NG; i++) game_rgb[12*i +: 12] = 12'($urandom_range(1, 4095));
        game_done = '0;
        pointAtBar(g);
        checkOutput("menu_bar_pix", vga, 12'hFFF);
        alignPhase(0);
        btn_sel_n = 1'b0;
        btn_up_n  = ~with_up;
        lc = 0;
        running = 1'b0;
        for (int i = 0; i < 30 && !running; i++) begin
            stepCycle();
            if (game_start != '0) running = 1'b1;
            else if (vga == 12'h000) begin
                lc++;
                checkOutput("launch_rst_n", game_rst_n, 0);
            end
        end
        checkOutput("launch_len", lc, 2);
        checkOutput("run_start", game_start, 1 << g);
        checkOutput("run_rst_n", game_rst_n, 1 << g);
        checkOutput("run_sel", active_game, g);
        checkOutput("run_pix", vga, slice(g));
        game_rgb[12*g +: 12] = 12'($urandom_range(1, 4095));
        #1;
        checkOutput("run_pix_comb", vga, slice(g));
        btn_sel_n = 1'b1;
        btn_up_n  = 1'b1;
    endtask

    // Non-selected done is ignored, then the selected done runs RESULT.
    task automatic finishGame(input int g);
        logic [NG-1:0] others;
        int rc;
        bit back;
        bit first;
        others = NG'($urandom) & ~(NG'(1) << g);
        if (others == '0) others = NG'(1) << ((g + 1) % NG);
        game_done = others;
        repeat (2 * TD) stepCycle();
        checkOutput("other_done_ignored", game_start, 1 << g);
        alignPhase(TD - 1);
        game_done = others | (NG'(1) << g);
        rc = 0;
        back = 1'b0;
        first = 1'b1;
        for (int i = 0; i < 60 && !back; i++) begin
            stepCycle();
            game_done = '0;
            if (game_rst_n == '0) back = 1'b1;
            else begin
                rc++;
                if (first) begin
                    checkOutput("result_start", game_start, 0);
                    checkOutput("result_rst_n", game_rst_n, 1 << g);
                    checkOutput("result_pix", vga, slice(g));
                    first = 1'b0;
                end
            end
        end
        checkOutput("result_len", rc, RT * TD);
        checkOutput("menu_start", game_start, 0);
        checkOutput("menu_sel_kept", active_game, g);
        checkOutput("menu_pix_back", vga, 12'hFFF);
    endtask

    initial begin
        int g;
        int rn;
        int act;
        vectors     = 0;
        miscompares = 0;
        model_sel   = 0;
        rst         = 1'b1;
        btn_up_n    = 1'b1;
        btn_down_n  = 1'b1;
        btn_sel_n   = 1'b1;
        game_done   = '0;
        game_rgb    = '0;
        x           = 10'd300;
        y           = 9'd110;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_sel", active_game, 0);
        checkOutput("rst_start", game_start, 0);
        checkOutput("rst_rst_n", game_rst_n, 0);
        checkOutput("rst_pix", vga, 12'hFFF);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed wrap checks, then up+down together.
        repeat (5) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);

        // Random menu navigation and random menu pixels.
        for (int i = 0; i < 12; i++) begin
            act = $urandom_range(0, 3);
            applyStimulus(act == 0 || act == 2, act == 1 || act == 2);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = 10'($urandom_range(180, 460));
                    y = 9'($urandom_range(80, 420));
                end else begin
                    x = 10'($urandom_range(0, 639));
                    y = 9'($urandom_range(0, 479));
                end
                #1;
                checkOutput("menu_pix", vga, menuPixel(int'(x), int'(y), model_sel));
            end
        end

        // Game 2, then a random game launched with up held (launch wins).
        navigateTo(2);
        launchGame(2, 1'b0);
        finishGame(2);
        g = $urandom_range(0, NG - 1);
        navigateTo(g);
        launchGame(g, 1'b1);
        finishGame(g);

        // Idle behaviour in RUN with no presses.
        g = $urandom_range(0, NG - 1);
        navigateTo(g);
        launchGame(g, 1'b0);
`ifdef ARCADE_IDLE_TIMEOUT_EN
        rn = 1;
        for (int i = 0; i < 100 && game_start != '0; i++) begin
            stepCycle();
            if (game_start != '0) rn++;
        end
        checkOutput("idle_not_early", rn >= (IT - 1) * TD + 1, 1);
        checkOutput("idle_not_late", rn <= IT * TD, 1);
        checkOutput("idle_rst_n", game_rst_n, 0);
        checkOutput("idle_sel", active_game, g);
`else
        rn = 0;
        repeat (IT * TD + 2 * TD) stepCycle();
        checkOutput("no_idle_exit", game_start, 1 << g);
        finishGame(g);
`endif

        // Asynchronous reset in the middle of RUN.
        g = $urandom_range(1, NG - 1);
        navigateTo(g);
        launchGame(g, 1'b0);
        repeat (5) stepCycle();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_start", game_start, 0);
        checkOutput("async_rst_rst_n", game_rst_n, 0);
        checkOutput("async_rst_sel", active_game, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_sel = 0;
        pointAtBar(0);
        checkOutput("post_rst_pix", vga, 12'hFFF);
        applyStimulus(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
